// File: rtl/mult_div_unit_if.sv
// Bundles the operand, control and result signals of mult_div_unit.
// master: the issuing side (operands, op, start, mthi/mtlo); slave: the unit itself.
// Ports: data1/data2/op/start/mthi/mtlo toward the unit; hi/lo/busy/done back from it.
interface mult_div_unit_if #(
    parameter int WIDTH = 32
);
    logic [WIDTH-1:0] data1;
    logic [WIDTH-1:0] data2;
    logic [1:0]       op;
    logic             start;
    logic             mthi;
    logic             mtlo;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;
    logic             busy;
    logic             done;

    modport master (
        output data1, data2, op, start, mthi, mtlo,
        input  hi, lo, busy, done
    );

    modport slave (
        input  data1, data2, op, start, mthi, mtlo,
        output hi, lo, busy, done
    );
endinterface

// File: rtl/mult_div_unit.sv
// Iterative MIPS-style HI/LO multiply/divide unit (MULT, MULTU, DIV, DIVU, MTHI, MTLO).
// Latency: WIDTH+1 cycles from the accepted start edge to HI/LO update; done pulses one cycle.
// Backpressure: none queued; start/mthi/mtlo are dropped while busy is high.
// Ports: clk, rst (sync, active-low), bus (slave modport: data1, data2, op, start, mthi, mtlo,
//        hi, lo, busy, done).
module mult_div_unit #(
    parameter int WIDTH = 32
) (
    input  logic           clk,
    input  logic           rst,
    mult_div_unit_if.slave bus
);
    localparam int CNT_W = $clog2(WIDTH);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2
    } state_t;

    state_t state;
    state_t state_nxt;

    logic [CNT_W-1:0] cnt;
    logic             is_div;
    logic             neg_lo;   // multiply: negate full product; divide: negate quotient
    logic             neg_hi;   // divide: negate remainder
    logic [WIDTH-1:0] opa;      // multiplicand magnitude
    logic [WIDTH-1:0] opb;      // divisor magnitude
    logic [WIDTH-1:0] acc_hi;   // product upper half / partial remainder
    logic [WIDTH-1:0] acc_lo;   // multiplier then product lower half / dividend then quotient
    logic [WIDTH-1:0] hi_r;
    logic [WIDTH-1:0] lo_r;
    logic             done_r;

    // Operand conditioning at launch; op[0]=0 selects the signed variants.
    logic             sign_a;
    logic             sign_b;
    logic [WIDTH-1:0] mag_a;
    logic [WIDTH-1:0] mag_b;
    logic             b_zero;

    always_comb begin
        sign_a = bus.data1[WIDTH-1] & ~bus.op[0];
        sign_b = bus.data2[WIDTH-1] & ~bus.op[0];
        mag_a  = sign_a ? (~bus.data1 + 1'b1) : bus.data1;
        mag_b  = sign_b ? (~bus.data2 + 1'b1) : bus.data2;
        b_zero = (bus.data2 == '0);
    end

    // One radix-2 step of each algorithm; only the one matching is_div is used.
    logic [WIDTH:0] mul_sum;
    logic [WIDTH:0] div_shift;
    logic [WIDTH:0] div_diff;
    logic           div_ge;

    always_comb begin
        mul_sum   = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, opa} : '0);
        div_shift = {acc_hi, acc_lo[WIDTH-1]};
        div_ge    = (div_shift >= {1'b0, opb});
        div_diff  = div_shift - {1'b0, opb};
    end

    // Sign fix-up applied in FIX. Magnitude of 0x80000000 survives negation unchanged,
    // which is exactly what the overflow case 0x80000000 / -1 needs.
    logic [2*WIDTH-1:0] prod;
    logic [2*WIDTH-1:0] prod_fix;
    logic [WIDTH-1:0]   quo_fix;
    logic [WIDTH-1:0]   rem_fix;

    always_comb begin
        prod     = {acc_hi, acc_lo};
        prod_fix = neg_lo ? (~prod + 1'b1) : prod;
        quo_fix  = neg_lo ? (~acc_lo + 1'b1) : acc_lo;
        rem_fix  = neg_hi ? (~acc_hi + 1'b1) : acc_hi;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (bus.start) state_nxt = CALC;
            CALC:    if (cnt == CNT_W'(WIDTH-1)) state_nxt = FIX;
            FIX:     state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            cnt    <= '0;
            is_div <= 1'b0;
            neg_lo <= 1'b0;
            neg_hi <= 1'b0;
            opa    <= '0;
            opb    <= '0;
            acc_hi <= '0;
            acc_lo <= '0;
            hi_r   <= '0;
            lo_r   <= '0;
            done_r <= 1'b0;
        end else begin
            done_r <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        cnt    <= '0;
                        is_div <= bus.op[1];
                        opa    <= mag_a;
                        opb    <= mag_b;
                        acc_hi <= '0;
                        acc_lo <= bus.op[1] ? mag_a : mag_b;
                        // Divide by zero keeps the quotient all ones and lets the
                        // remainder sign restore A exactly.
                        neg_lo <= (sign_a ^ sign_b) & ~(bus.op[1] & b_zero);
                        neg_hi <= sign_a;
                    end else begin
                        if (bus.mthi) hi_r <= bus.data1;
                        if (bus.mtlo) lo_r <= bus.data1;
                    end
                end
                CALC: begin
                    cnt <= cnt + 1'b1;
                    if (is_div) begin
                        acc_hi <= div_ge ? div_diff[WIDTH-1:0] : div_shift[WIDTH-1:0];
                        acc_lo <= {acc_lo[WIDTH-2:0], div_ge};
                    end else begin
                        acc_hi <= mul_sum[WIDTH:1];
                        acc_lo <= {mul_sum[0], acc_lo[WIDTH-1:1]};
                    end
                end
                FIX: begin
                    done_r <= 1'b1;
                    if (is_div) begin
                        hi_r <= rem_fix;
                        lo_r <= quo_fix;
                    end else begin
                        hi_r <= prod_fix[2*WIDTH-1:WIDTH];
                        lo_r <= prod_fix[WIDTH-1:0];
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.hi   = hi_r;
    assign bus.lo   = lo_r;
    assign bus.busy = (state != IDLE);
    assign bus.done = done_r;
endmodule

// File: tb/tb_mult_div_unit.sv
module tb_mult_div_unit;
    localparam int W = 32;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    mult_div_unit_if #(.WIDTH(W)) bus ();

    mult_div_unit #(.WIDTH(W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int tests = 0;
    int fails = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Architectural result of one operation: {HI, LO}.
    function automatic logic [63:0] ref_result(input logic [1:0] op, input logic [31:0] a,
                                               input logic [31:0] b);
        longint sa, sb, q, r;
        logic [63:0] ua, ub;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = {32'b0, a};
        ub = {32'b0, b};
        case (op)
            2'd0: return 64'(sa * sb);
            2'd1: return ua * ub;
            2'd2: begin
                if (b == 32'd0) return {a, 32'hFFFF_FFFF};
                q = sa / sb;
                r = sa % sb;
                return {r[31:0], q[31:0]};
            end
            default: begin
                if (b == 32'd0) return {a, 32'hFFFF_FFFF};
                return {a % b, a / b};
            end
        endcase
    endfunction

    // Model: a request accepted while idle resolves WIDTH+1 edges later.
    logic [31:0] m_hi = '0, m_lo = '0;
    logic [63:0] m_res = '0;
    logic        m_busy = 1'b0, m_done = 1'b0, m_valid = 1'b0;
    int          m_left = 0;

    always @(posedge clk) begin
        if (!rst) begin
            m_hi    <= '0;
            m_lo    <= '0;
            m_busy  <= 1'b0;
            m_done  <= 1'b0;
            m_left  <= 0;
            m_valid <= 1'b1;
        end else begin
            m_done <= 1'b0;
            if (m_busy) begin
                m_left <= m_left - 1;
                if (m_left == 1) begin
                    m_hi   <= m_res[63:32];
                    m_lo   <= m_res[31:0];
                    m_done <= 1'b1;
                    m_busy <= 1'b0;
                end
            end else if (bus.start) begin
                m_res  <= ref_result(bus.op, bus.data1, bus.data2);
                m_busy <= 1'b1;
                m_left <= W + 1;
            end else begin
                if (bus.mthi) m_hi <= bus.data1;
                if (bus.mtlo) m_lo <= bus.data1;
            end
        end
    end

    always @(negedge clk) begin
        if (m_valid) begin
            check("cyc_hi", bus.hi, m_hi);
            check("cyc_lo", bus.lo, m_lo);
            check("cyc_busy", {31'b0, bus.busy}, {31'b0, m_busy});
            check("cyc_done", {31'b0, bus.done}, {31'b0, m_done});
        end
    end

    // Entered right after a negedge; returns right after the negedge following the start edge.
    task automatic start_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                            input logic mtx);
        bus.op    = op;
        bus.data1 = a;
        bus.data2 = b;
        bus.start = 1'b1;
        bus.mthi  = mtx;
        bus.mtlo  = mtx;
        @(negedge clk);
        bus.start = 1'b0;
        bus.mthi  = 1'b0;
        bus.mtlo  = 1'b0;
    endtask

    // Scramble every input while busy; the in-flight operation must not notice.
    task automatic noise(output int cycles);
        cycles = 0;
        for (int i = 0; i < 3; i++) begin
            bus.data1 = $urandom;
            bus.data2 = $urandom;
            bus.op    = 2'($urandom_range(0, 3));
            bus.start = 1'b1;
            bus.mthi  = 1'b1;
            bus.mtlo  = 1'b1;
            @(negedge clk);
            cycles++;
        end
        bus.start = 1'b0;
        bus.mthi  = 1'b0;
        bus.mtlo  = 1'b0;
    endtask

    task automatic wait_done(input string name, input logic [31:0] eh, input logic [31:0] el,
                             input int k0);
        int k;
        k = k0;
        while (bus.done !== 1'b1 && k < 100) begin
            @(negedge clk);
            k++;
        end
        if (bus.done !== 1'b1) begin
            tests++;
            fails++;
            $display("FAIL %s_timeout: done not seen, got %0d cycles, expected %0d", name, k, W + 1);
        end else begin
            check({name, "_lat"}, 32'(k), 32'(W + 1));
            check({name, "_hi"}, bus.hi, eh);
            check({name, "_lo"}, bus.lo, el);
        end
        @(negedge clk);
    endtask

    initial begin
        int nc;
        int pulses;
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected $finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int nc;
        int pulses;
        bus.data1 = '0;
        bus.data2 = '0;
        bus.op    = '0;
        bus.start = 1'b0;
        bus.mthi  = 1'b0;
        bus.mtlo  = 1'b0;
        rst       = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_hi", bus.hi, 32'h0);
        check("rst_lo", bus.lo, 32'h0);
        check("rst_busy", {31'b0, bus.busy}, 32'h0);
        check("rst_done", {31'b0, bus.done}, 32'h0);
        rst = 1'b1;
        @(negedge clk);

        start_op(2'd0, 32'hFFFF_FFFD, 32'd5, 1'b0);
        wait_done("mult_neg3x5", 32'hFFFF_FFFF, 32'hFFFF_FFF1, 0);

        start_op(2'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
        noise(nc);
        wait_done("multu_max", 32'hFFFF_FFFE, 32'h0000_0001, nc);

        start_op(2'd2, 32'hFFFF_FFF9, 32'd2, 1'b0);
        wait_done("div_neg7by2", 32'hFFFF_FFFF, 32'hFFFF_FFFD, 0);

        start_op(2'd3, 32'd7, 32'd0, 1'b0);
        wait_done("divu_by0", 32'h0000_0007, 32'hFFFF_FFFF, 0);

        start_op(2'd2, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
        noise(nc);
        wait_done("div_ovf", 32'h0000_0000, 32'h8000_0000, nc);

        start_op(2'd2, 32'hFFFF_FFFB, 32'd0, 1'b0);
        wait_done("div_neg_by0", 32'hFFFF_FFFB, 32'hFFFF_FFFF, 0);

        start_op(2'd2, 32'd7, 32'hFFFF_FFFE, 1'b0);
        wait_done("div_7byneg2", 32'h0000_0001, 32'hFFFF_FFFD, 0);

        start_op(2'd0, 32'h8000_0000, 32'h8000_0000, 1'b0);
        wait_done("mult_minsq", 32'h4000_0000, 32'h0000_0000, 0);

        start_op(2'd3, 32'hFFFF_FFFF, 32'd10, 1'b0);
        wait_done("divu_by10", 32'h0000_0005, 32'h1999_9999, 0);

        start_op(2'd0, 32'd7, 32'hFFFF_FFFE, 1'b0);
        wait_done("mult_7xneg2", 32'hFFFF_FFFF, 32'hFFFF_FFF2, 0);

        // Move-to-HI/LO while idle, then start wins over mthi/mtlo in the same cycle.
        bus.data1 = 32'h1234_5678;
        bus.mthi  = 1'b1;
        bus.mtlo  = 1'b1;
        @(negedge clk);
        bus.mthi  = 1'b0;
        bus.mtlo  = 1'b0;
        check("mthi", bus.hi, 32'h1234_5678);
        check("mtlo", bus.lo, 32'h1234_5678);
        start_op(2'd1, 32'hCAFE_BABE, 32'd3, 1'b1);
        check("start_prio_hi", bus.hi, 32'h1234_5678);
        check("start_prio_lo", bus.lo, 32'h1234_5678);
        wait_done("multu_cafe", 32'h0000_0002, 32'h60FC_303A, 0);

        // Reset ten cycles into a multiply aborts it silently.
        start_op(2'd0, 32'd3, 32'd5, 1'b0);
        repeat (9) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        check("abort_busy", {31'b0, bus.busy}, 32'h0);
        check("abort_hi", bus.hi, 32'h0);
        check("abort_lo", bus.lo, 32'h0);
        pulses = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (bus.done === 1'b1) pulses++;
        end
        check("abort_no_done", 32'(pulses), 32'h0);
        check("abort_hi_hold", bus.hi, 32'h0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
